exe_stage_ctrl: RTL and testbench

//  Execute-stage sequencer around the FU datapath: holds one FU_REQUIRE in a valid/ready stage

---
 rtl/exe_stage_ctrl_pkg.sv | 31 +++
 rtl/exe_stage_ctrl_sat_counter.sv | 16 +
 rtl/exe_stage_ctrl.sv | 92 +++++++++
 tb/tb_exe_stage_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_ctrl_pkg.sv
// Shared types for the execute-stage sequencer: FU request/response structs and FSM state.
package exe_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    alu    = 2'd0,
    brunch = 2'd1,
    load   = 2'd2,
    store  = 2'd3
  } EXE_TYPE;

  typedef struct packed {
    EXE_TYPE     exe_type;
    logic [4:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
  } FU_REQUIRE;

  typedef struct packed {
    logic        enable;
    logic [31:0] pc_new;
  } PC_CHECK;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } MEM_REQUIRE;

  typedef enum logic {EXE_RUN, EXE_REDIR} EXE_CTRL_STATE;

endpackage

// File: rtl/exe_stage_ctrl_sat_counter.sv
// Saturating up-counter used for the execute-stage performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   out <= '0;
    else if (inc && out != '1) out <= out + W'(1);
  end

endmodule

// File: rtl/exe_stage_ctrl.sv
// Execute-stage sequencer: one-entry valid/ready stage feeding the FU, with a held
// frontend redirect handshake and wrong-path flush after a mispredicted branch.
module exe_stage_ctrl
  import exe_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  FU_REQUIRE        in_req,
  output FU_REQUIRE        fu_require,
  input  PC_CHECK          pc_execute,
  input  MEM_REQUIRE       mem_require,
  output logic             out_valid,
  input  logic             out_ready,
  output MEM_REQUIRE       out_mem,
  output logic             flush_o,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
);

  EXE_CTRL_STATE state;
  logic          ex_valid;
  FU_REQUIRE     ex_req;
  logic          in_redir, handoff, mispredict, accept;

  // ex_valid is always clear in REDIR, so handoff cannot fire there.
  assign in_redir   = (state == EXE_REDIR);
  assign handoff    = ex_valid & out_ready;
  assign mispredict = handoff & pc_execute.enable;
  assign in_ready   = in_redir | !ex_valid | (out_ready & !pc_execute.enable);
  assign accept     = !in_redir & in_valid & in_ready;

  assign out_valid  = ex_valid;
  assign out_mem    = mem_require;
  assign fu_require = ex_req;
  assign flush_o    = in_redir | mispredict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= EXE_RUN;
      ex_valid       <= 1'b0;
      ex_req         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        EXE_RUN: begin
          if (mispredict) begin
            state          <= EXE_REDIR;
            ex_valid       <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= pc_execute.pc_new;
          end else if (accept) begin
            ex_valid <= 1'b1;
            ex_req   <= in_req;
          end else if (handoff) begin
            ex_valid <= 1'b0;
          end
        end
        EXE_REDIR: begin
          // Issue offers are dropped here, including on the handshake cycle.
          if (redirect_ready) begin
            state          <= EXE_RUN;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= EXE_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk (clk),
    .rst (rst),
    .inc (handoff && ex_req.exe_type == brunch),
    .out (cnt_branch)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispredict (
    .clk (clk),
    .rst (rst),
    .inc (mispredict),
    .out (cnt_mispredict)
  );

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Bench for exe_stage_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_exe_stage_ctrl;
  import exe_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, redirect_ready;
  FU_REQUIRE   in_req, fu_require, fu_require_s;
  PC_CHECK     pc_execute;
  MEM_REQUIRE  mem_require, out_mem, out_mem_s;
  logic        in_ready, out_valid, flush_o, redirect_valid;
  logic        in_ready_s, out_valid_s, flush_o_s, redirect_valid_s;
  logic [31:0] redirect_pc, redirect_pc_s;
  logic [15:0] cnt_branch, cnt_mispredict;
  logic [1:0]  cnt_branch_s, cnt_mispredict_s;

  int nvec = 0, nerr = 0;
  int exp_br = 0, exp_mis = 0;

  always #5 clk = ~clk;

  exe_stage_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .fu_require(fu_require), .pc_execute(pc_execute), .mem_require(mem_require),
    .out_valid(out_valid), .out_ready(out_ready), .out_mem(out_mem), .flush_o(flush_o),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict)
  );

  // Narrow-counter copy sees identical stimulus; used for saturation checks.
  exe_stage_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_req(in_req),
    .fu_require(fu_require_s), .pc_execute(pc_execute), .mem_require(mem_require),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_mem(out_mem_s), .flush_o(flush_o_s),
    .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s), .redirect_ready(redirect_ready),
    .cnt_branch(cnt_branch_s), .cnt_mispredict(cnt_mispredict_s)
  );

  function automatic MEM_REQUIRE fu_mem(FU_REQUIRE r);
    MEM_REQUIRE m;
    m.we   = (r.exe_type != store);
    m.rd   = r.op;
    m.data = (r.exe_type == brunch) ? r.pc + 32'd4 : r.pc ^ r.imm;
    return m;
  endfunction

  function automatic logic is_mis(FU_REQUIRE r);
    return (r.exe_type == brunch) && r.op[0];
  endfunction

  function automatic FU_REQUIRE mk(EXE_TYPE t, logic [31:0] pc, logic [31:0] imm, logic mis);
    FU_REQUIRE r;
    r.exe_type = t;
    r.op       = {pc[5:2], mis};
    r.pc       = pc;
    r.imm      = imm;
    return r;
  endfunction

  function automatic logic [1:0] sat2(int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  // FU model: a branch flagged in op[0] mispredicts to its imm.
  always_comb begin
    mem_require       = fu_mem(fu_require);
    pc_execute.enable = is_mis(fu_require);
    pc_execute.pc_new = fu_require.imm;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; redirect_ready = 1'b0; in_req = '0;
    @(negedge clk);
    nvec++;
    if ({out_valid, in_ready, flush_o, redirect_valid} !== 4'b0100) begin
      nerr++; $display("FAIL reset_ctl got %b want 0100", {out_valid, in_ready, flush_o, redirect_valid});
    end
    nvec++;
    if ({redirect_pc, cnt_branch, cnt_mispredict, cnt_mispredict_s} !== 66'd0) begin
      nerr++; $display("FAIL reset_regs got pc=%h br=%0d mis=%0d", redirect_pc, cnt_branch, cnt_mispredict);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_br = 0; exp_mis = 0;
  endtask

  task automatic test_alu_stream();
    FU_REQUIRE r[3];
    for (int i = 0; i < 3; i++) r[i] = mk(alu, 32'h1000 + 32'(4 * i), $urandom, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      if (k < 3) in_req = r[k];
      @(negedge clk);
      nvec++;
      if ({out_valid, in_ready} !== {1'(k >= 1 && k <= 3), 1'b1}) begin
        nerr++; $display("FAIL stream_ctl cyc%0d got %b want %b", k, {out_valid, in_ready}, {1'(k >= 1 && k <= 3), 1'b1});
      end
      if (k >= 1 && k <= 3) begin
        nvec++;
        if (out_mem !== fu_mem(r[k-1])) begin
          nerr++; $display("FAIL stream_data cyc%0d got %h want %h", k, out_mem, fu_mem(r[k-1]));
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    FU_REQUIRE r[3];
    logic [6:0] rdy_tab = 7'b1100011;  // out_ready per cycle, bit k = cycle k
    logic [6:0] irdy_tab = 7'b1100011; // expected in_ready per cycle
    int exp_idx[7] = '{-1, 0, 1, 1, 1, 1, 2};
    int p = 0;
    for (int i = 0; i < 3; i++) r[i] = mk(alu, 32'h2000 + 32'(8 * i), $urandom, 1'b0);
    for (int k = 0; k < 7; k++) begin
      out_ready = rdy_tab[k];
      in_valid  = (p < 3);
      if (p < 3) in_req = r[p];
      @(negedge clk);
      nvec++;
      if ({out_valid, in_ready} !== {1'(exp_idx[k] >= 0), irdy_tab[k]}) begin
        nerr++; $display("FAIL bp_ctl cyc%0d got %b want %b", k, {out_valid, in_ready}, {1'(exp_idx[k] >= 0), irdy_tab[k]});
      end
      if (exp_idx[k] >= 0) begin
        nvec++;
        if (out_mem !== fu_mem(r[exp_idx[k]]) || fu_require !== r[exp_idx[k]]) begin
          nerr++; $display("FAIL bp_data cyc%0d got %h want %h", k, out_mem, fu_mem(r[exp_idx[k]]));
        end
      end
      if (in_valid && irdy_tab[k]) p++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mispredict();
    FU_REQUIRE br   = mk(brunch, 32'h40, 32'h100, 1'b1);
    FU_REQUIRE x    = mk(alu, 32'h200, 32'h5, 1'b0);
    FU_REQUIRE junk = mk(alu, 32'hdead0, 32'h7, 1'b0);
    logic [3:0] ctl_tab[7] = '{4'b0100, 4'b1010, 4'b0111, 4'b0111, 4'b0111, 4'b0100, 4'b1100};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid       = (k != 6);
      in_req         = (k == 0) ? br : (k == 5) ? x : junk;
      redirect_ready = (k == 4);
      @(negedge clk);
      nvec++;
      if ({out_valid, in_ready, flush_o, redirect_valid} !== ctl_tab[k]) begin
        nerr++; $display("FAIL mis_ctl cyc%0d got %b want %b", k, {out_valid, in_ready, flush_o, redirect_valid}, ctl_tab[k]);
      end
      if (k >= 2 && k <= 4) begin
        nvec++;
        if (redirect_pc !== 32'h100) begin
          nerr++; $display("FAIL mis_pc cyc%0d got %h want 00000100", k, redirect_pc);
        end
      end
      if (k == 1 || k == 6) begin
        nvec++;
        if (out_mem !== fu_mem(k == 1 ? br : x)) begin
          nerr++; $display("FAIL mis_data cyc%0d got %h want %h", k, out_mem, fu_mem(k == 1 ? br : x));
        end
      end
      if (k == 6) begin
        exp_br++; exp_mis++;
        nvec++;
        if (cnt_branch !== 16'(exp_br) || cnt_mispredict !== 16'(exp_mis)) begin
          nerr++; $display("FAIL mis_cnt got br=%0d mis=%0d want br=%0d mis=%0d", cnt_branch, cnt_mispredict, exp_br, exp_mis);
        end
      end
      tick();
    end
    in_valid = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic test_predicted_jump();
    FU_REQUIRE j = mk(brunch, 32'h300, 32'h400, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1; in_req = j;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if ({out_valid, in_ready, flush_o, redirect_valid} !== 4'b1100 || out_mem !== fu_mem(j)) begin
      nerr++; $display("FAIL jump_out got %b %h want 1100 %h", {out_valid, in_ready, flush_o, redirect_valid}, out_mem, fu_mem(j));
    end
    tick();
    exp_br++;
    @(negedge clk);
    nvec++;
    if ({flush_o, redirect_valid} !== 2'b00 || cnt_branch !== 16'(exp_br) || cnt_mispredict !== 16'(exp_mis)) begin
      nerr++; $display("FAIL jump_cnt got br=%0d mis=%0d want br=%0d mis=%0d", cnt_branch, cnt_mispredict, exp_br, exp_mis);
    end
    tick();
  endtask

  task automatic test_random();
    FU_REQUIRE q[$];
    logic redir = 1'b0;
    logic [31:0] rpc = '0;
    logic e_ov, e_ir, e_fl, hf, mis;
    for (int n = 0; n < 600; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_req         = mk(EXE_TYPE'($urandom_range(0, 3)), $urandom, $urandom, ($urandom_range(0, 3) == 0));
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      e_ov = !redir && q.size() != 0;
      hf   = e_ov && out_ready;
      mis  = hf && is_mis(q[0]);
      e_ir = redir || !e_ov || (out_ready && !is_mis(q[0]));
      e_fl = redir || mis;
      nvec++;
      if ({out_valid, in_ready, flush_o, redirect_valid} !== {e_ov, e_ir, e_fl, redir}) begin
        nerr++; $display("FAIL rnd_ctl n%0d got %b want %b", n, {out_valid, in_ready, flush_o, redirect_valid}, {e_ov, e_ir, e_fl, redir});
      end
      if (e_ov) begin
        nvec++;
        if (out_mem !== fu_mem(q[0])) begin
          nerr++; $display("FAIL rnd_data n%0d got %h want %h", n, out_mem, fu_mem(q[0]));
        end
      end
      if (redir) begin
        nvec++;
        if (redirect_pc !== rpc) begin
          nerr++; $display("FAIL rnd_pc n%0d got %h want %h", n, redirect_pc, rpc);
        end
      end
      nvec++;
      if (cnt_branch !== 16'(exp_br) || cnt_mispredict !== 16'(exp_mis) ||
          cnt_mispredict_s !== sat2(exp_mis) || cnt_branch_s !== sat2(exp_br)) begin
        nerr++; $display("FAIL rnd_cnt n%0d got br=%0d mis=%0d mis_s=%0d want br=%0d mis=%0d", n, cnt_branch, cnt_mispredict, cnt_mispredict_s, exp_br, exp_mis);
      end
      if (redir) begin
        if (redirect_ready) redir = 1'b0;
      end else begin
        if (hf) begin
          if (q[0].exe_type == brunch) exp_br++;
          if (mis) begin exp_mis++; redir = 1'b1; rpc = q[0].imm; end
          void'(q.pop_front());
        end
        if (in_valid && e_ir) q.push_back(in_req);
      end
      tick();
    end
    in_valid = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    rst = 1'b1; #2; rst = 1'b0;
    exp_br = 0; exp_mis = 0;
    out_ready = 1'b1; redirect_ready = 1'b0;
    in_valid = 1'b1; in_req = mk(brunch, 32'h500, 32'h900, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    nvec++;
    if ({out_valid, in_ready, flush_o, redirect_valid} !== 4'b0111 || cnt_mispredict !== 16'd1) begin
      nerr++; $display("FAIL arst_pre got %b mis=%0d want 0111 mis=1", {out_valid, in_ready, flush_o, redirect_valid}, cnt_mispredict);
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({out_valid, in_ready, flush_o, redirect_valid} !== 4'b0100 || cnt_mispredict !== 16'd0 || redirect_pc !== 32'd0) begin
      nerr++; $display("FAIL arst_now got %b mis=%0d pc=%h want 0100 mis=0 pc=0", {out_valid, in_ready, flush_o, redirect_valid}, cnt_mispredict, redirect_pc);
    end
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_req = mk(alu, 32'h600, 32'h3, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if ({out_valid, flush_o, redirect_valid} !== 3'b100 || out_mem !== fu_mem(mk(alu, 32'h600, 32'h3, 1'b0)) ||
        cnt_branch !== 16'd0 || cnt_mispredict_s !== 2'd0) begin
      nerr++; $display("FAIL arst_after got %b %h br=%0d", {out_valid, flush_o, redirect_valid}, out_mem, cnt_branch);
    end
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; redirect_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_req = mk(brunch, 32'h700 + 32'(16 * i), 32'h100 + 32'(i), 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      nvec++;
      if (cnt_mispredict_s !== sat2(i) || cnt_branch_s !== sat2(i) || cnt_mispredict !== 16'(i)) begin
        nerr++; $display("FAIL sat i%0d got mis_s=%0d br_s=%0d mis=%0d want mis_s=%0d mis=%0d", i, cnt_mispredict_s, cnt_branch_s, cnt_mispredict, sat2(i), i);
      end
      tick();
    end
    redirect_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_stream();
    test_backpressure();
    test_mispredict();
    test_predicted_jump();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
